// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Holds the FSM state encoding and the requester count.
// Imported by ram_arbiter and rr_pick2.
package ram_arb_pkg;

  localparam int REQ_CNT = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    READ_CAP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational winner select between two requesters.
// Zero latency; winner is only meaningful when at least one req is high.
// Round-robin on `last` by default; RAM_ARB_FIXED_PRIO_EN selects fixed priority (0 wins).
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [REQ_CNT-1:0] req,
  input  logic               last,
  output logic               winner
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Fixed priority ignores the previous winner entirely.
  logic unused_last;
  assign unused_last = last;

  // Requester 0 wins whenever it asks; requester 1 only when 0 is silent.
  always_comb begin
    winner = 1'b0;
    if (!req[0] && req[1]) winner = 1'b1;
  end
`else
  // On a tie the requester that did not win last time goes next; a lone requester always wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port RAM with a shared tristate data bus.
// Latency: gnt 1 cycle after req sample; write done +2, read done/rdata +3.
// Backpressure: req is held until gnt; req only sampled in IDLE. Macro: RAM_ARB_FIXED_PRIO_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_CNT-1:0]    req,
  input  logic [REQ_CNT-1:0]    req_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic [REQ_CNT-1:0]    gnt,
  output logic [REQ_CNT-1:0]    done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  arb_state_t            state;
  logic                  last;
  logic                  owner;
  logic                  winner;
  logic [DATA_WIDTH-1:0] wdata_q;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

  // The controller drives the bus only while writing, so READ/READ_CAP never collide with it.
  assign ram_data = (state == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

  // Sequencer: accept and latch a request in IDLE, then walk the RAM access with registered controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      wdata_q  <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      ram_addr <= '0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner       <= winner;
            last        <= winner;
            gnt[winner] <= 1'b1;
            ram_addr    <= winner ? req1_addr : req0_addr;
            wdata_q     <= winner ? req1_wdata : req0_wdata;
            ram_cs      <= 1'b1;
            if (req_we[winner]) begin
              state  <= WRITE;
              ram_we <= 1'b1;
              ram_oe <= 1'b0;
            end else begin
              state  <= READ;
              ram_we <= 1'b0;
              ram_oe <= 1'b1;
            end
          end
        end
        WRITE: begin
          state       <= IDLE;
          done[owner] <= 1'b1;
          ram_cs      <= 1'b0;
          ram_we      <= 1'b0;
          ram_oe      <= 1'b0;
        end
        READ: begin
          // RAM registers the word at the end of this cycle; controls stay as they are.
          state <= READ_CAP;
        end
        READ_CAP: begin
          state       <= IDLE;
          rdata       <= ram_data;
          done[owner] <= 1'b1;
          ram_cs      <= 1'b0;
          ram_we      <= 1'b0;
          ram_oe      <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
